// File: rtl/pc_sequencer.sv
// Program sequencer: PC register, next-PC select, C/Z flags and a return-address stack.
// Define PC_SEQ_CIRCULAR_STACK_EN to make a push-when-full overwrite the oldest entry.
module pc_sequencer #(
    parameter int unsigned     PC_W     = 12,
    parameter int unsigned     OFF_W    = 8,
    parameter int unsigned     DEPTH    = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic [2:0]                 op,
    input  logic [2:0]                 cond,
    input  logic [OFF_W-1:0]           offset,
    input  logic [PC_W-1:0]            target,
    input  logic                       c_in,
    input  logic                       z_in,
    input  logic                       write_c,
    input  logic                       write_z,
    output logic [PC_W-1:0]            pc,
    output logic                       C,
    output logic                       Z,
    output logic [$clog2(DEPTH+1)-1:0] stack_depth,
    output logic                       stack_empty,
    output logic                       stack_full,
    output logic                       stack_ovf,
    output logic                       stack_unf
);

    localparam int unsigned DEPTH_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W   = $clog2(DEPTH);

    localparam logic [2:0] OP_BRANCH = 3'b001;
    localparam logic [2:0] OP_JUMP   = 3'b010;
    localparam logic [2:0] OP_CALL   = 3'b011;
    localparam logic [2:0] OP_RET    = 3'b100;

    logic [PC_W-1:0]    stack_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, wr_ptr_nxt, top_ptr;
    logic [PC_W-1:0]    pc1, off_ext, pc_nxt;
    logic [DEPTH_W-1:0] depth_nxt;
    logic               c_nxt, z_nxt, ovf_nxt, unf_nxt, push_en, taken;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        return (p == '0) ? PTR_W'(DEPTH - 1) : p - PTR_W'(1);
    endfunction

    // Offset is sign-extended, or truncated when it is at least as wide as the PC.
    generate
        if (OFF_W >= PC_W) begin : g_off_trunc
            assign off_ext = offset[PC_W-1:0];
        end else begin : g_off_sext
            assign off_ext = {{(PC_W - OFF_W){offset[OFF_W-1]}}, offset};
        end
    endgenerate

    assign pc1     = pc + PC_W'(1);
    assign top_ptr = ptr_dec(wr_ptr);

    always_comb begin
        taken = 1'b0;
        case (cond)
            3'b000:  taken = 1'b1;
            3'b001:  taken = Z;
            3'b010:  taken = ~Z;
            3'b011:  taken = C;
            3'b100:  taken = ~C;
            default: taken = 1'b0;
        endcase
    end

    // Next-state selection; stall leaves every default in place.
    always_comb begin
        pc_nxt     = pc;
        c_nxt      = C;
        z_nxt      = Z;
        depth_nxt  = stack_depth;
        wr_ptr_nxt = wr_ptr;
        ovf_nxt    = stack_ovf;
        unf_nxt    = stack_unf;
        push_en    = 1'b0;
        if (!stall) begin
            pc_nxt = pc1;
            if (write_c) c_nxt = c_in;
            if (write_z) z_nxt = z_in;
            case (op)
                OP_BRANCH: if (taken) pc_nxt = pc1 + off_ext;
                OP_JUMP:   pc_nxt = target;
                OP_CALL: begin
                    pc_nxt = target;
                    if (stack_full) begin
                        ovf_nxt = 1'b1;
`ifdef PC_SEQ_CIRCULAR_STACK_EN
                        push_en    = 1'b1;
                        wr_ptr_nxt = ptr_inc(wr_ptr);
`endif
                    end else begin
                        push_en    = 1'b1;
                        wr_ptr_nxt = ptr_inc(wr_ptr);
                        depth_nxt  = stack_depth + DEPTH_W'(1);
                    end
                end
                OP_RET: begin
                    if (stack_empty) begin
                        unf_nxt = 1'b1;
                    end else begin
                        pc_nxt     = stack_mem[top_ptr];
                        wr_ptr_nxt = top_ptr;
                        depth_nxt  = stack_depth - DEPTH_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            C           <= 1'b0;
            Z           <= 1'b0;
            stack_depth <= '0;
            stack_empty <= 1'b1;
            stack_full  <= 1'b0;
            stack_ovf   <= 1'b0;
            stack_unf   <= 1'b0;
            wr_ptr      <= '0;
        end else begin
            pc          <= pc_nxt;
            C           <= c_nxt;
            Z           <= z_nxt;
            stack_depth <= depth_nxt;
            stack_empty <= (depth_nxt == '0);
            stack_full  <= (depth_nxt == DEPTH_W'(DEPTH));
            stack_ovf   <= ovf_nxt;
            stack_unf   <= unf_nxt;
            wr_ptr      <= wr_ptr_nxt;
        end
    end

    // Return-address storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push_en) stack_mem[wr_ptr] <= pc1;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random traffic against a queue-based model.
module tb_pc_sequencer;

    localparam int PC_W    = 12;
    localparam int OFF_W   = 8;
    localparam int DEPTH   = 8;
    localparam int PC_MASK = (1 << PC_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1, stall = 1'b0;
    logic [2:0]        op = 3'b010, cond = 3'b000;
    logic [OFF_W-1:0]  offset = '0;
    logic [PC_W-1:0]   target = 12'h3A5;
    logic              c_in = 1'b0, z_in = 1'b0, write_c = 1'b0, write_z = 1'b0;
    logic [PC_W-1:0]   pc;
    logic              C, Z;
    logic [$clog2(DEPTH+1)-1:0] stack_depth;
    logic              stack_empty, stack_full, stack_ovf, stack_unf;

    pc_sequencer #(.PC_W(PC_W), .OFF_W(OFF_W), .DEPTH(DEPTH), .RESET_PC('0)) dut (
        .clk(clk), .reset(reset), .stall(stall), .op(op), .cond(cond),
        .offset(offset), .target(target), .c_in(c_in), .z_in(z_in),
        .write_c(write_c), .write_z(write_z), .pc(pc), .C(C), .Z(Z),
        .stack_depth(stack_depth), .stack_empty(stack_empty), .stack_full(stack_full),
        .stack_ovf(stack_ovf), .stack_unf(stack_unf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    int m_pc;
    bit m_c, m_z, m_ovf, m_unf;
    int stk[$];

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        n_checks++;
        if (got !== 32'(exp)) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_edge();
        int  pc1, soff, npc;
        bit  tk;
        if (reset) begin
            m_pc = 0; m_c = 0; m_z = 0; m_ovf = 0; m_unf = 0;
            stk.delete();
            return;
        end
        if (stall) return;
        pc1  = (m_pc + 1) & PC_MASK;
        soff = int'($signed(offset));
        case (cond)
            3'd0: tk = 1;
            3'd1: tk = m_z;
            3'd2: tk = !m_z;
            3'd3: tk = m_c;
            3'd4: tk = !m_c;
            default: tk = 0;
        endcase
        npc = pc1;
        case (op)
            3'd1: if (tk) npc = (pc1 + soff) & PC_MASK;
            3'd2: npc = int'(target);
            3'd3: begin
                npc = int'(target);
                if (stk.size() == DEPTH) begin
                    m_ovf = 1;
`ifdef PC_SEQ_CIRCULAR_STACK_EN
                    void'(stk.pop_front());
                    stk.push_back(pc1);
`endif
                end else begin
                    stk.push_back(pc1);
                end
            end
            3'd4: begin
                if (stk.size() == 0) m_unf = 1;
                else npc = stk.pop_back();
            end
            default: ;
        endcase
        m_pc = npc;
        if (write_c) m_c = c_in;
        if (write_z) m_z = z_in;
    endfunction

    task automatic compare_all();
        check("pc", 32'(pc), m_pc);
        check("C", 32'(C), int'(m_c));
        check("Z", 32'(Z), int'(m_z));
        check("depth", 32'(stack_depth), stk.size());
        check("empty", 32'(stack_empty), int'(stk.size() == 0));
        check("full", 32'(stack_full), int'(stk.size() == DEPTH));
        check("ovf", 32'(stack_ovf), int'(m_ovf));
        check("unf", 32'(stack_unf), int'(m_unf));
    endtask

    // One clock: model and DUT advance on the same edge, outputs sampled 1ns later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive(input logic [2:0] o, input logic [2:0] cd,
                         input logic [7:0] off, input logic [11:0] tgt);
        op = o; cond = cd; offset = off; target = tgt;
        step();
        write_c = 0; write_z = 0;
    endtask

    int push_addr[9];
    int p_save;
    int d_save;

    initial begin
        // Reset held two cycles with a JUMP pending.
        step();
        step();
        check("rst_pc", 32'(pc), 0);
        check("rst_empty", 32'(stack_empty), 1);
        reset = 0;
        for (int i = 1; i <= 3; i++) begin
            drive(3'd0, 3'd0, 8'h00, 12'h000);
            check("next_pc", 32'(pc), i);
        end

        // Branch on Z, flag written one cycle before.
        write_z = 1; z_in = 1;
        drive(3'd2, 3'd0, 8'h00, 12'h00F);
        drive(3'd0, 3'd0, 8'h00, 12'h000);
        drive(3'd1, 3'd1, 8'hFC, 12'h000);
        check("br_z", 32'(pc), 'h00D);
        drive(3'd2, 3'd0, 8'h00, 12'h010);
        drive(3'd1, 3'd2, 8'hFC, 12'h000);
        check("br_nz", 32'(pc), 'h011);
        // Same-edge flag write must not affect this branch.
        write_z = 1; z_in = 0;
        drive(3'd2, 3'd0, 8'h00, 12'h010);
        write_z = 1; z_in = 1;
        drive(3'd1, 3'd1, 8'hFC, 12'h000);
        check("br_same_edge", 32'(pc), 'h011);

        // Wrap-around.
        drive(3'd2, 3'd0, 8'h00, 12'hFFF);
        drive(3'd0, 3'd0, 8'h00, 12'h000);
        check("wrap_next", 32'(pc), 0);
        drive(3'd2, 3'd0, 8'h00, 12'hFFE);
        drive(3'd1, 3'd0, 8'h05, 12'h000);
        check("wrap_br", 32'(pc), 'h004);

        // Nested call/return.
        drive(3'd2, 3'd0, 8'h00, 12'h020);
        drive(3'd3, 3'd0, 8'h00, 12'h100);
        check("call1_depth", 32'(stack_depth), 1);
        for (int i = 0; i < 5; i++) drive(3'd0, 3'd0, 8'h00, 12'h000);
        drive(3'd3, 3'd0, 8'h00, 12'h200);
        check("call2_depth", 32'(stack_depth), 2);
        drive(3'd4, 3'd0, 8'h00, 12'h000);
        check("ret1_pc", 32'(pc), 'h106);
        drive(3'd4, 3'd0, 8'h00, 12'h000);
        check("ret2_pc", 32'(pc), 'h021);
        check("ret2_empty", 32'(stack_empty), 1);

        // Overflow: nine calls from known PCs.
        for (int k = 0; k < 9; k++) begin
            push_addr[k] = (int'(pc) + 1) & PC_MASK;
            drive(3'd3, 3'd0, 8'h00, 12'(12'h300 + k * 16));
        end
        check("ovf_full", 32'(stack_full), 1);
        check("ovf_flag", 32'(stack_ovf), 1);
        check("ovf_pc", 32'(pc), 'h300 + 8 * 16);
        for (int j = 0; j < 8; j++) begin
            drive(3'd4, 3'd0, 8'h00, 12'h000);
`ifdef PC_SEQ_CIRCULAR_STACK_EN
            check("ovf_ret", 32'(pc), push_addr[8 - j]);
`else
            check("ovf_ret", 32'(pc), push_addr[7 - j]);
`endif
        end
        p_save = int'(pc);
        drive(3'd4, 3'd0, 8'h00, 12'h000);
        check("unf_pc", 32'(pc), (p_save + 1) & PC_MASK);
        check("unf_flag", 32'(stack_unf), 1);

        // Stall holds everything, including flag writes.
        p_save = int'(pc);
        d_save = int'(stack_depth);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            write_c = 1; c_in = 1;
            drive(3'd3, 3'd0, 8'h00, 12'h400);
        end
        check("stall_pc", 32'(pc), p_save);
        check("stall_depth", 32'(stack_depth), d_save);
        check("stall_c", 32'(C), 0);
        stall = 0;
        drive(3'd3, 3'd0, 8'h00, 12'h400);
        check("unstall_depth", 32'(stack_depth), d_save + 1);
        check("unstall_pc", 32'(pc), 'h400);

        // Random traffic; calls and returns weighted up to exercise the stack.
        for (int n = 0; n < 3000; n++) begin
            int r;
            reset   = ($urandom_range(0, 199) == 0);
            stall   = ($urandom_range(0, 9) == 0);
            r       = int'($urandom_range(0, 9));
            op      = (r < 3) ? 3'd3 : (r < 6) ? 3'd4 : 3'($urandom_range(0, 7));
            cond    = 3'($urandom_range(0, 7));
            offset  = 8'($urandom);
            target  = 12'($urandom);
            c_in    = 1'($urandom);
            z_in    = 1'($urandom);
            write_c = 1'($urandom);
            write_z = 1'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
